blit_mem_arbiter: RTL
=====================

BLIT_MEM_ARBITER -- requirements
Module: blit_mem_arbiter

Interface
REQ-001 Parameter MAX_WRITE_RUN, default 16: maximum consecutive write grants while a read is pending.
REQ-002 clock  in  1  sole clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 blitr_sdram_request  in  1, blitr_sdram_address  in  26, blitr_sdram_ready  out  1: blitter read-burst request port.
REQ-005 blitr_sdram_rvalid  out  1, blitr_sdram_rdata  out  32, blitr_sdram_raddress  out  26, blitr_sdram_complete  out  1: read return to blitter.
REQ-006 blitw_sdram_request  in  1, blitw_sdram_address  in  26, blitw_sdram_wstrb  in  4, blitw_sdram_wdata  in  32, blitw_sdram_ready  out  1: blitter write port.
REQ-007 sdram_request  out  1, sdram_write  out  1, sdram_address  out  26, sdram_wstrb  out  4, sdram_wdata  out  32: single merged master port to SDRAM arbiter.
REQ-008 sdram_ready  in  1, sdram_rvalid  in  1, sdram_rdata  in  32, sdram_raddress  in  26, sdram_complete  in  1: merged port responses.

Function
REQ-009 Sources hold request and payload stable until their ready pulse; a ready pulse accepts exactly one request (read = one burst, write = one word).
REQ-010 States: IDLE, ISSUE_RD, ISSUE_WR; plus flag rd_outstanding and counter write_run (width clog2(MAX_WRITE_RUN)+1, saturating).
REQ-011 Read eligible = blitr_sdram_request && !rd_outstanding (registered flag); write eligible = blitw_sdram_request.
REQ-012 Arbitration (in IDLE, or in an ISSUE state on the cycle sdram_ready=1): both eligible -> write if write_run < MAX_WRITE_RUN else read; only one eligible -> it; none -> IDLE.
REQ-013 Decision registered: chosen ISSUE state entered next cycle; first sdram_request one cycle after source request seen in IDLE.
REQ-014 ISSUE_RD: sdram_request=1, sdram_write=0, sdram_address=blitr_sdram_address, sdram_wstrb=0, sdram_wdata=0.
REQ-015 ISSUE_WR: sdram_request=1, sdram_write=1, address/wstrb/wdata from blitw port.
REQ-016 IDLE: sdram_request=0, sdram_write=0, address/wstrb/wdata=0.
REQ-017 blitr_sdram_ready = sdram_ready && state==ISSUE_RD; blitw_sdram_ready = sdram_ready && state==ISSUE_WR; combinational, same cycle; never both high.
REQ-018 State stays in ISSUE_x while sdram_ready=0, regardless of other requests (no preemption).
REQ-019 Read accepted (ISSUE_RD && sdram_ready) sets rd_outstanding next cycle; sdram_complete && rd_outstanding clears it next cycle; set and clear never coincide.
REQ-020 Writes may be granted while rd_outstanding=1; second read not granted until rd_outstanding cleared (earliest grant decision the cycle after complete).
REQ-021 blitr_sdram_rvalid/rdata/raddress/complete = sdram_* passed combinationally, gated by rd_outstanding (rvalid, complete forced 0, rdata/raddress 0 when flag clear).
REQ-022 write_run: +1 on each write acceptance (saturating); cleared on read acceptance; cleared when blitr_sdram_request=0.
REQ-023 Rvalid/complete arriving with rd_outstanding=0 are dropped.

Reset
REQ-024 Reset: state IDLE, rd_outstanding=0, write_run=0; all outputs 0 same cycle reset sampled high and next.
REQ-025 Reset mid-ISSUE or mid-burst abandons the access; no ready emitted; later returned data dropped per REQ-023.
REQ-026 First grant possible in the cycle after reset deasserts.

Verification
REQ-027 Write only: blitw request addr 0x0000100, wdata 0xDEADBEEF, wstrb 0xF, sdram_ready at second ISSUE cycle -> sdram_write=1 with those values, blitw_sdram_ready single pulse coincident with sdram_ready.
REQ-028 Read burst: blitr addr 0x0001000, 4 rvalid beats then complete -> beats forwarded unchanged, rd_outstanding 1 during burst, 0 the cycle after complete.
REQ-029 Fairness: both request continuously, sdram_ready=1 each ISSUE cycle -> exactly 16 writes then 1 read, write_run then 0.
REQ-030 Write during burst: read outstanding, write requested -> write granted and accepted; second read request withheld until after complete.
REQ-031 Stall: sdram_ready held 0 for 10 cycles in ISSUE_WR while read requests -> no switch, outputs stable, both source readies 0.
REQ-032 Reset mid-burst: reset after 2 of 4 beats -> outputs 0, remaining rvalids not forwarded, next read granted normally.

Source files
------------

// File: rtl/blit_mem_arbiter.sv
// blit_mem_arbiter
//   Merges the blitter read-burst port and the blitter write port onto a
//   single SDRAM master port. Writes are favoured, but only up to
//   MAX_WRITE_RUN consecutive grants while a read is waiting. Only one read
//   burst may be outstanding at a time. Writes may still proceed during that
//   burst.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   blitr_sdram_*         : read request in, ready out; burst return out
//                           (rvalid/rdata/raddress/complete)
//   blitw_sdram_*         : write request/address/wstrb/wdata in, ready out
//   sdram_* (outputs)     : merged request/write/address/wstrb/wdata
//   sdram_* (inputs)      : ready, and read return (rvalid/rdata/raddress/complete)
module blit_mem_arbiter #(
    parameter int unsigned MAX_WRITE_RUN = 16
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        blitr_sdram_request,
    input  logic [25:0] blitr_sdram_address,
    output logic        blitr_sdram_ready,
    output logic        blitr_sdram_rvalid,
    output logic [31:0] blitr_sdram_rdata,
    output logic [25:0] blitr_sdram_raddress,
    output logic        blitr_sdram_complete,

    input  logic        blitw_sdram_request,
    input  logic [25:0] blitw_sdram_address,
    input  logic [3:0]  blitw_sdram_wstrb,
    input  logic [31:0] blitw_sdram_wdata,
    output logic        blitw_sdram_ready,

    output logic        sdram_request,
    output logic        sdram_write,
    output logic [25:0] sdram_address,
    output logic [3:0]  sdram_wstrb,
    output logic [31:0] sdram_wdata,
    input  logic        sdram_ready,
    input  logic        sdram_rvalid,
    input  logic [31:0] sdram_rdata,
    input  logic [25:0] sdram_raddress,
    input  logic        sdram_complete
);

    localparam int unsigned RUN_W = $clog2(MAX_WRITE_RUN) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_RD = 2'd1,
        ISSUE_WR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rd_outstanding_q, rd_outstanding_d;
    logic [RUN_W-1:0] write_run_q, write_run_d;

    logic rd_accept, wr_accept, rd_elig, wr_elig, decide;

    always_comb begin
        rd_accept = (state_q == ISSUE_RD) && sdram_ready;
        wr_accept = (state_q == ISSUE_WR) && sdram_ready;

        // The read being accepted this cycle is not eligible again, because
        // its outstanding flag only becomes visible next cycle.
        rd_elig = blitr_sdram_request && !rd_outstanding_q && (state_q != ISSUE_RD);
        wr_elig = blitw_sdram_request;

        write_run_d = write_run_q;
        if (!blitr_sdram_request || rd_accept) begin
            write_run_d = '0;
        end else if (wr_accept && (write_run_q < RUN_W'(MAX_WRITE_RUN))) begin
            write_run_d = write_run_q + RUN_W'(1);
        end

        rd_outstanding_d = rd_outstanding_q;
        if (rd_accept) begin
            rd_outstanding_d = 1'b1;
        end else if (sdram_complete && rd_outstanding_q) begin
            rd_outstanding_d = 1'b0;
        end

        // Arbitrate against the run count including this cycle's acceptance,
        // so a read wins straight after the MAX_WRITE_RUN-th write.
        decide  = (state_q == IDLE) || sdram_ready;
        state_d = state_q;
        if (decide) begin
            if (rd_elig && wr_elig) begin
                state_d = (write_run_d < RUN_W'(MAX_WRITE_RUN)) ? ISSUE_WR : ISSUE_RD;
            end else if (rd_elig) begin
                state_d = ISSUE_RD;
            end else if (wr_elig) begin
                state_d = ISSUE_WR;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            rd_outstanding_q <= 1'b0;
            write_run_q      <= '0;
        end else begin
            state_q          <= state_d;
            rd_outstanding_q <= rd_outstanding_d;
            write_run_q      <= write_run_d;
        end
    end

    // Outputs decode the registered state. Reset also gates them directly,
    // so they read zero in the cycle reset is first sampled.
    always_comb begin
        sdram_request        = 1'b0;
        sdram_write          = 1'b0;
        sdram_address        = '0;
        sdram_wstrb          = '0;
        sdram_wdata          = '0;
        blitr_sdram_ready    = 1'b0;
        blitw_sdram_ready    = 1'b0;
        blitr_sdram_rvalid   = 1'b0;
        blitr_sdram_rdata    = '0;
        blitr_sdram_raddress = '0;
        blitr_sdram_complete = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ISSUE_RD: begin
                    sdram_request     = 1'b1;
                    sdram_address     = blitr_sdram_address;
                    blitr_sdram_ready = sdram_ready;
                end
                ISSUE_WR: begin
                    sdram_request     = 1'b1;
                    sdram_write       = 1'b1;
                    sdram_address     = blitw_sdram_address;
                    sdram_wstrb       = blitw_sdram_wstrb;
                    sdram_wdata       = blitw_sdram_wdata;
                    blitw_sdram_ready = sdram_ready;
                end
                default: ;
            endcase
            if (rd_outstanding_q) begin
                blitr_sdram_rvalid   = sdram_rvalid;
                blitr_sdram_rdata    = sdram_rdata;
                blitr_sdram_raddress = sdram_raddress;
                blitr_sdram_complete = sdram_complete;
            end
        end
    end

endmodule
